// File: rtl/button_debounce.sv
// Push-button conditioner: input synchroniser, bounce filter and clean level.
// Emits one-cycle rise/fall pulses and a busy flag while a change qualifies.
module button_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic button_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                   raw_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  assign raw_n = ACTIVE_LOW ? ~button_i : button_i;
  assign s_q   = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_n};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // A reversion on the terminal sample wins over qualification.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        cnt_d = '0;
        if (s_q) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (!s_q) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        cnt_d = '0;
        if (!s_q) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (s_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign busy_o  = (state_q == WAIT_HI) || (state_q == WAIT_LO);

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: two instances, active-high and
// active-low pads, both with a 4-cycle debounce window.
module tb_button_debounce;

  logic clk = 1'b0;
  logic rst_n, b_rst_n;
  logic a_btn, b_btn;
  logic a_level, a_rise, a_fall, a_busy;
  logic b_level, b_rise, b_fall, b_busy;

  int n_checks = 0;
  int n_err    = 0;
  int a_rise_n, a_fall_n, a_busy_n;
  int b_rise_n, b_fall_n;

  always #5 clk = ~clk;

  button_debounce #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b0)
  ) u_a (
    .clk_i(clk),
    .rst_ni(rst_n),
    .button_i(a_btn),
    .level_o(a_level),
    .rise_o(a_rise),
    .fall_o(a_fall),
    .busy_o(a_busy)
  );

  button_debounce #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b1)
  ) u_b (
    .clk_i(clk),
    .rst_ni(b_rst_n),
    .button_i(b_btn),
    .level_o(b_level),
    .rise_o(b_rise),
    .fall_o(b_fall),
    .busy_o(b_busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    a_rise_n = 0;
    a_fall_n = 0;
    a_busy_n = 0;
    b_rise_n = 0;
    b_fall_n = 0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (a_rise === 1'b1) a_rise_n++;
      if (a_fall === 1'b1) a_fall_n++;
      if (a_busy === 1'b1) a_busy_n++;
      if (b_rise === 1'b1) b_rise_n++;
      if (b_fall === 1'b1) b_fall_n++;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    b_rst_n = 1'b0;
    a_btn   = 1'b0;
    b_btn   = 1'b0;
    clr();
    #12;
    check("rst_level", a_level, 0);
    check("rst_rise", a_rise, 0);
    check("rst_fall", a_fall, 0);
    check("rst_busy", a_busy, 0);
    check("b_rst_level", b_level, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3);
    check("idle_level", a_level, 0);

    // clean press
    clr();
    a_btn = 1'b1;
    step(6);
    check("press_e6_level", a_level, 0);
    step(1);
    check("press_e7_level", a_level, 1);
    check("press_e7_rise", a_rise, 1);
    step(1);
    check("press_e8_rise", a_rise, 0);
    check("press_rise_n", a_rise_n, 1);
    check("press_busy_n", a_busy_n, 4);

    // release
    clr();
    a_btn = 1'b0;
    step(6);
    check("rel_e6_level", a_level, 1);
    step(1);
    check("rel_e7_level", a_level, 0);
    check("rel_e7_fall", a_fall, 1);
    step(1);
    check("rel_e8_fall", a_fall, 0);
    check("rel_fall_n", a_fall_n, 1);
    check("rel_rise_n", a_rise_n, 0);

    // bounce then hold
    clr();
    for (int k = 0; k < 4; k++) begin
      a_btn = (k % 2 == 0) ? 1'b1 : 1'b0;
      step(2);
    end
    a_btn = 1'b1;
    step(6);
    check("bnc_level", a_level, 0);
    check("bnc_rise_n", a_rise_n, 0);
    step(1);
    check("bnc_e7_level", a_level, 1);
    check("bnc_e7_rise", a_rise, 1);
    step(2);
    check("bnc_rise_once", a_rise_n, 1);
    a_btn = 1'b0;
    step(8);
    check("bnc_back_lo", a_level, 0);

    // glitch on the terminal sample
    clr();
    a_btn = 1'b1;
    step(4);
    a_btn = 1'b0;
    step(10);
    check("glt_level", a_level, 0);
    check("glt_rise_n", a_rise_n, 0);
    check("glt_busy", a_busy, 0);
    check("glt_busy_n", a_busy_n, 4);

    // reset in the middle of WAIT_HI
    a_btn = 1'b1;
    step(5);
    check("mid_busy", a_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_level", a_level, 0);
    check("mid_rst_rise", a_rise, 0);
    check("mid_rst_busy", a_busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr();
    step(6);
    check("held_e6_level", a_level, 0);
    step(1);
    check("held_e7_level", a_level, 1);
    check("held_e7_rise", a_rise, 1);
    step(3);
    check("held_rise_n", a_rise_n, 1);

    // active-low pad held low from reset release
    clr();
    b_btn = 1'b0;
    b_rst_n = 1'b1;
    step(6);
    check("al_e6_level", b_level, 0);
    step(1);
    check("al_e7_level", b_level, 1);
    check("al_e7_rise", b_rise, 1);
    step(1);
    check("al_rise_n", b_rise_n, 1);
    b_btn = 1'b1;
    step(6);
    check("al_rel_e6_level", b_level, 1);
    step(1);
    check("al_rel_e7_level", b_level, 0);
    check("al_rel_fall", b_fall, 1);
    step(2);
    check("al_fall_n", b_fall_n, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
